// File: rtl/win_banner_pkg.sv
// Shared types and screen constants for the win banner position driver.
package win_banner_pkg;

   localparam int unsigned COORD_W  = 11;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLIDE = 2'd1,
      BLINK = 2'd2,
      HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/rect_hit_reg.sv
// Registered rectangle hit test and pixel offsets for one object.
// WIN_BANNER_SCALE2X_EN doubles the rectangle and halves the offsets.
module rect_hit_reg
   import win_banner_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned HEIGHT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [COORD_W-1:0] topLeftX,
   input  logic [COORD_W-1:0] topLeftY,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   output logic [COORD_W-1:0] offsetX,
   output logic [COORD_W-1:0] offsetY,
   output logic               InsideRectangle
);

`ifdef WIN_BANNER_SCALE2X_EN
   localparam int unsigned SCALE_SH = 1;
`else
   localparam int unsigned SCALE_SH = 0;
`endif

   localparam coord_t RECT_W = COORD_W'(WIDTH << SCALE_SH);
   localparam coord_t RECT_H = COORD_W'(HEIGHT << SCALE_SH);

   logic   in_x_c;
   logic   in_y_c;
   logic   hit_c;
   coord_t dx_c;
   coord_t dy_c;

   // Right/bottom edges stay inside 11 bits for every on-screen top-left.
   assign in_x_c = (pixelX >= topLeftX) && (pixelX < coord_t'(topLeftX + RECT_W));
   assign in_y_c = (pixelY >= topLeftY) && (pixelY < coord_t'(topLeftY + RECT_H));
   assign hit_c  = enable && in_x_c && in_y_c;
   assign dx_c   = coord_t'(pixelX - topLeftX);
   assign dy_c   = coord_t'(pixelY - topLeftY);

   always_ff @(posedge clk) begin
      if (reset) begin
         InsideRectangle <= 1'b0;
         offsetX         <= '0;
         offsetY         <= '0;
      end else begin
         InsideRectangle <= hit_c;
         offsetX         <= hit_c ? coord_t'(dx_c >> SCALE_SH) : '0;
         offsetY         <= hit_c ? coord_t'(dy_c >> SCALE_SH) : '0;
      end
   end

endmodule

// File: rtl/win_banner_ctrl.sv
// Win banner animator: slide up, blink, hold; drives the rect hit stage.
// Optional macro WIN_BANNER_SCALE2X_EN selects a double-size banner.
module win_banner_ctrl
   import win_banner_pkg::*;
#(
   parameter int unsigned OBJECT_WIDTH  = 64,
   parameter int unsigned OBJECT_HEIGHT = 16,
   parameter int unsigned FINAL_X       = 288,
   parameter int unsigned FINAL_Y       = 232,
   parameter int unsigned START_Y       = SCREEN_H,
   parameter int unsigned SLIDE_STEP    = 4,
   parameter int unsigned BLINK_PERIOD  = 16,
   parameter int unsigned BLINK_TOGGLES = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                startOfFrame,
   input  logic [COORD_W-1:0]  pixelX,
   input  logic [COORD_W-1:0]  pixelY,
   input  logic                winTrigger,
   input  logic                gameRestart,
   output logic [COORD_W-1:0]  offsetX,
   output logic [COORD_W-1:0]  offsetY,
   output logic                InsideRectangle,
   output logic                bannerActive,
   output logic                sequenceDone
);

   localparam int unsigned FRAME_W = $clog2(BLINK_PERIOD);
   localparam int unsigned TOG_W   = $clog2(BLINK_TOGGLES + 1);

   state_t             state, state_n;
   coord_t             top_y, top_y_n;
   logic               visible, visible_n;
   logic [FRAME_W-1:0] frame_cnt, frame_cnt_n;
   logic [TOG_W-1:0]   toggle_cnt, toggle_cnt_n;
   coord_t             slid_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         top_y        <= COORD_W'(START_Y);
         visible      <= 1'b0;
         frame_cnt    <= '0;
         toggle_cnt   <= '0;
         bannerActive <= 1'b0;
         sequenceDone <= 1'b0;
      end else begin
         state        <= state_n;
         top_y        <= top_y_n;
         visible      <= visible_n;
         frame_cnt    <= frame_cnt_n;
         toggle_cnt   <= toggle_cnt_n;
         bannerActive <= (state_n != IDLE);
         sequenceDone <= (state_n == HOLD);
      end
   end

   // Position/visibility only move on startOfFrame; restart wins over everything.
   always_comb begin
      state_n      = state;
      top_y_n      = top_y;
      visible_n    = visible;
      frame_cnt_n  = frame_cnt;
      toggle_cnt_n = toggle_cnt;
      slid_c       = coord_t'(top_y - COORD_W'(SLIDE_STEP));

      if (gameRestart) begin
         state_n      = IDLE;
         top_y_n      = COORD_W'(START_Y);
         visible_n    = 1'b0;
         frame_cnt_n  = '0;
         toggle_cnt_n = '0;
      end else begin
         case (state)
            IDLE: begin
               if (winTrigger) begin
                  state_n   = SLIDE;
                  top_y_n   = COORD_W'(START_Y);
                  visible_n = 1'b1;
               end
            end
            SLIDE: begin
               if (startOfFrame) begin
                  if (slid_c <= COORD_W'(FINAL_Y)) begin
                     top_y_n      = COORD_W'(FINAL_Y);
                     state_n      = BLINK;
                     frame_cnt_n  = '0;
                     toggle_cnt_n = '0;
                  end else begin
                     top_y_n = slid_c;
                  end
               end
            end
            BLINK: begin
               if (startOfFrame) begin
                  if (frame_cnt == FRAME_W'(BLINK_PERIOD - 1)) begin
                     frame_cnt_n  = '0;
                     visible_n    = ~visible;
                     toggle_cnt_n = toggle_cnt + TOG_W'(1);
                     if (toggle_cnt == TOG_W'(BLINK_TOGGLES - 1)) begin
                        state_n      = HOLD;
                        visible_n    = 1'b1;
                        toggle_cnt_n = '0;
                     end
                  end else begin
                     frame_cnt_n = frame_cnt + FRAME_W'(1);
                  end
               end
            end
            HOLD: begin
               visible_n = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   rect_hit_reg #(
      .WIDTH  (OBJECT_WIDTH),
      .HEIGHT (OBJECT_HEIGHT)
   ) u_rect_hit (
      .clk             (clk),
      .reset           (reset),
      .enable          (visible),
      .topLeftX        (COORD_W'(FINAL_X)),
      .topLeftY        (top_y),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle)
   );

endmodule

// File: tb/tb_win_banner_ctrl.sv
// Self-checking bench for win_banner_ctrl; expected hit/offsets queued per probe.
module tb_win_banner_ctrl;

`ifdef WIN_BANNER_SCALE2X_EN
   localparam int SH = 1;
`else
   localparam int SH = 0;
`endif

   typedef struct packed {
      logic        hit;
      logic [10:0] ox;
      logic [10:0] oy;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        startOfFrame = 1'b0;
   logic [10:0] pixelX = '0;
   logic [10:0] pixelY = '0;
   logic        winTrigger = 1'b0;
   logic        gameRestart = 1'b0;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        InsideRectangle;
   logic        bannerActive;
   logic        sequenceDone;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_err = 0;
   int   m_top = 480;
   bit   m_vis = 1'b0;

   always #5 clk = ~clk;

   win_banner_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .startOfFrame    (startOfFrame),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .winTrigger      (winTrigger),
      .gameRestart     (gameRestart),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .InsideRectangle (InsideRectangle),
      .bannerActive    (bannerActive),
      .sequenceDone    (sequenceDone)
   );

   // Reference hit test from the bench's own idea of top-left Y and visibility.
   function automatic exp_t model(input int x, input int y);
      exp_t r;
      int   w, h;
      w = 64 << SH;
      h = 16 << SH;
      r = '0;
      if (m_vis && x >= 288 && x < 288 + w && y >= m_top && y < m_top + h) begin
         r.hit = 1'b1;
         r.ox  = 11'((x - 288) >> SH);
         r.oy  = 11'((y - m_top) >> SH);
      end
      return r;
   endfunction

   task automatic probe(input int x, input int y);
      pixelX = 11'(x);
      pixelY = 11'(y);
      sb.push_back(model(x, y));
      @(posedge clk); #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         startOfFrame = 1'b1;
         @(posedge clk); #1;
         startOfFrame = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_win();
      winTrigger = 1'b1;
      @(posedge clk); #1;
      winTrigger = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY, bannerActive, sequenceDone} !== 25'd0) begin
         n_err++;
         $display("FAIL reset_outputs got hit=%0b ox=%0d oy=%0d act=%0b done=%0b want all 0",
                  InsideRectangle, offsetX, offsetY, bannerActive, sequenceDone);
      end
      pulse_win();
      frames(5);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      m_vis = 1'b0;
      m_top = 480;
      n_checks++;
      if (bannerActive !== 1'b0 || InsideRectangle !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_slide got act=%0b hit=%0b want 0/0", bannerActive, InsideRectangle);
      end
      probe(300, 490);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== e) begin
         n_err++;
         $display("FAIL reset_idle_probe got %0b/%0d/%0d want %0b/%0d/%0d",
                  InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
      end
      pulse_win();
      m_vis = 1'b1;
      n_checks++;
      if (bannerActive !== 1'b1) begin
         n_err++;
         $display("FAIL trigger_active got %0b want 1", bannerActive);
      end
      // Top-left restarted at 480: a pixel below the screen edge must hit.
      probe(300, 490);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== e || e.hit !== 1'b1) begin
         n_err++;
         $display("FAIL slide_start_probe got %0b/%0d/%0d want %0b/%0d/%0d",
                  InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
      end
   endtask

   task automatic test_slide();
      int px[4] = '{300, 300, 300, 300};
      int py[4] = '{236, 235, 240, 231};
      frames(61);
      m_top = 236;
      for (int i = 0; i < 2; i++) begin
         probe(px[i], py[i]);
         e = sb.pop_front();
         n_checks++;
         if ({InsideRectangle, offsetX, offsetY} !== e) begin
            n_err++;
            $display("FAIL slide61_probe%0d got %0b/%0d/%0d want %0b/%0d/%0d",
                     i, InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
         end
      end
      frames(1);
      m_top = 232;
      for (int i = 2; i < 4; i++) begin
         probe(px[i], py[i]);
         e = sb.pop_front();
         n_checks++;
         if ({InsideRectangle, offsetX, offsetY} !== e) begin
            n_err++;
            $display("FAIL slide62_probe%0d got %0b/%0d/%0d want %0b/%0d/%0d",
                     i, InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
         end
      end
`ifndef WIN_BANNER_SCALE2X_EN
      probe(300, 240);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd12, 11'd8}) begin
         n_err++;
         $display("FAIL final_pos_offsets got %0b/%0d/%0d want 1/12/8",
                  InsideRectangle, offsetX, offsetY);
      end
`endif
      n_checks++;
      if (bannerActive !== 1'b1 || sequenceDone !== 1'b0) begin
         n_err++;
         $display("FAIL blink_status got act=%0b done=%0b want 1/0", bannerActive, sequenceDone);
      end
   endtask

   task automatic test_blink();
      int  nf[4]  = '{15, 1, 79, 1};
      bit  vis[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      bit  dn[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         frames(nf[i]);
         m_vis = vis[i];
         probe(300, 240);
         e = sb.pop_front();
         n_checks++;
         if ({InsideRectangle, offsetX, offsetY} !== e || sequenceDone !== dn[i]) begin
            n_err++;
            $display("FAIL blink_step%0d got %0b/%0d/%0d done=%0b want %0b/%0d/%0d done=%0b",
                     i, InsideRectangle, offsetX, offsetY, sequenceDone, e.hit, e.ox, e.oy, dn[i]);
         end
      end
      pulse_win();
      frames(2);
      n_checks++;
      if (sequenceDone !== 1'b1 || bannerActive !== 1'b1) begin
         n_err++;
         $display("FAIL hold_ignores_trigger got done=%0b act=%0b want 1/1", sequenceDone, bannerActive);
      end
   endtask

   task automatic test_edges();
      int px[7] = '{288, 351, 352, 288, 287, 415, 416};
      int py[7] = '{232, 247, 232, 248, 240, 263, 263};
      for (int i = 0; i < 7; i++) begin
         probe(px[i], py[i]);
         e = sb.pop_front();
         n_checks++;
         if ({InsideRectangle, offsetX, offsetY} !== e) begin
            n_err++;
            $display("FAIL edge(%0d,%0d) got %0b/%0d/%0d want %0b/%0d/%0d",
                     px[i], py[i], InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
         end
      end
`ifdef WIN_BANNER_SCALE2X_EN
      probe(415, 263);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd63, 11'd15}) begin
         n_err++;
         $display("FAIL scale_corner got %0b/%0d/%0d want 1/63/15", InsideRectangle, offsetX, offsetY);
      end
`else
      probe(351, 247);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== {1'b1, 11'd63, 11'd15}) begin
         n_err++;
         $display("FAIL unit_corner got %0b/%0d/%0d want 1/63/15", InsideRectangle, offsetX, offsetY);
      end
`endif
   endtask

   task automatic test_restart();
      gameRestart = 1'b1;
      winTrigger  = 1'b1;
      @(posedge clk); #1;
      gameRestart = 1'b0;
      winTrigger  = 1'b0;
      m_vis = 1'b0;
      m_top = 480;
      n_checks++;
      if (bannerActive !== 1'b0 || sequenceDone !== 1'b0) begin
         n_err++;
         $display("FAIL restart_priority got act=%0b done=%0b want 0/0", bannerActive, sequenceDone);
      end
      probe(300, 240);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== e) begin
         n_err++;
         $display("FAIL restart_idle_probe got %0b/%0d/%0d want %0b/%0d/%0d",
                  InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
      end
      pulse_win();
      m_vis = 1'b1;
      probe(300, 490);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== e || bannerActive !== 1'b1) begin
         n_err++;
         $display("FAIL retrigger_probe got %0b/%0d/%0d act=%0b want %0b/%0d/%0d act=1",
                  InsideRectangle, offsetX, offsetY, bannerActive, e.hit, e.ox, e.oy);
      end
      frames(1);
      m_top = 476;
      probe(300, 476);
      e = sb.pop_front();
      n_checks++;
      if ({InsideRectangle, offsetX, offsetY} !== e) begin
         n_err++;
         $display("FAIL retrigger_step got %0b/%0d/%0d want %0b/%0d/%0d",
                  InsideRectangle, offsetX, offsetY, e.hit, e.ox, e.oy);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_slide();
      test_blink();
      test_edges();
      test_restart();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
